// File: rtl/ddr_buf_pkg.sv
// Shared defaults, FSM state type and level-width helper for the DDR write
// pack buffer.
package ddr_buf_pkg;

  localparam int unsigned IN_W_DEF      = 32;
  localparam int unsigned OUT_W_DEF     = 256;
  localparam int unsigned DEPTH_DEF     = 512;
  localparam int unsigned BURST_LEN_DEF = 16;

  // Level counts 0..DEPTH inclusive, hence one bit beyond the pointer width.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned LEVEL_W_DEF = level_w(DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAD   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/buf_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module buf_sdp_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds between reads so the popped word stays visible.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ddr_wr_pack_buf.sv
// Packs narrow input words little-endian into wide words, buffers them for
// DDR bursts, and supports a pad-and-drain flush.
module ddr_wr_pack_buf
  import ddr_buf_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic                     ddr_clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     flush_done,
  input  logic                     out_rd_en,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     burst_req,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned RATIO  = OUT_W / IN_W;
  localparam int unsigned LANE_W = $clog2(RATIO);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = level_w(DEPTH);

  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [OUT_W-1:0]    pack_q, pack_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                out_valid_q, out_valid_d;
  logic                has_data_q, has_data_d;
  logic                burst_req_q, burst_req_d;
  logic                flush_done_q, flush_done_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                accept;
  logic                wr_en;
  logic [OUT_W-1:0]    wr_data;
  logic [OUT_W-1:0]    assembled;
  logic                rd_en;
  logic                rd_take;
  logic [OUT_W-1:0]    ram_rdata;

  assign in_ready = (state_q == ST_IDLE) && (level_q != LVL_FULL);
  assign accept   = in_valid && in_ready;
  assign rd_en    = out_rd_en && (level_q != '0);

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    has_data_d   = has_data_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    flush_done_d = 1'b0;
    wr_en        = 1'b0;
    wr_data      = pack_q;
    rd_take      = 1'b0;

    assembled = pack_q;
    assembled[lane_q*IN_W +: IN_W] = in_data;

    // Unused lanes of pack_q are kept at zero, so a padded write is just pack_q.
    if (accept) begin
      if (lane_q == LAST_LANE) begin
        wr_en   = 1'b1;
        wr_data = assembled;
        pack_d  = '0;
        lane_d  = '0;
      end else begin
        pack_d = assembled;
        lane_d = lane_q + LANE_W'(1);
      end
    end

    if ((state_q == ST_IDLE) && in_valid && !in_ready) overflow_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (flush) state_d = (lane_d != '0) ? ST_PAD : ST_DRAIN;
      end
      ST_PAD: begin
        if (level_q != LVL_FULL) begin
          wr_en   = 1'b1;
          wr_data = pack_q;
          pack_d  = '0;
          lane_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((level_q == '0) && !wr_en) begin
          flush_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop against an empty buffer that coincides with a write consumes
    // that write without reading it, keeping level unchanged.
    if (out_rd_en && (level_q == '0)) underflow_d = 1'b1;
    if (rd_en || (out_rd_en && wr_en)) rd_take = 1'b1;
    if (rd_en) has_data_d = 1'b1;
    if (rd_take) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    unique case ({wr_en, rd_take})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    out_valid_d = rd_en;
    burst_req_d = (level_q >= LVL_BURST) ||
                  ((state_q != ST_IDLE) && (level_q != '0));
  end

  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      pack_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_valid_q  <= 1'b0;
      has_data_q   <= 1'b0;
      burst_req_q  <= 1'b0;
      flush_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      out_valid_q  <= out_valid_d;
      has_data_q   <= has_data_d;
      burst_req_q  <= burst_req_d;
      flush_done_q <= flush_done_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  buf_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_ram (
    .clk     (ddr_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  // RAM output is unreset; report zero until the first real pop lands.
  assign out_data   = has_data_q ? ram_rdata : '0;
  assign out_valid  = out_valid_q;
  assign level      = level_q;
  assign burst_req  = burst_req_q;
  assign flush_done = flush_done_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_ddr_wr_pack_buf.sv
// Self-checking bench for ddr_wr_pack_buf: queue-based reference model,
// directed scenarios and a randomized soak.
module tb_ddr_wr_pack_buf;

  localparam int unsigned IN_W      = 32;
  localparam int unsigned OUT_W     = 256;
  localparam int unsigned DEPTH     = 512;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned RATIO     = OUT_W / IN_W;
  localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;

  logic              ddr_clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              in_ready;
  logic              flush;
  logic              flush_done;
  logic              out_rd_en;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic [LVL_W-1:0]  level;
  logic              burst_req;
  logic              overflow;
  logic              underflow;

  always #5 ddr_clk = ~ddr_clk;

  ddr_wr_pack_buf #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .ddr_clk    (ddr_clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .out_rd_en  (out_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .level      (level),
    .burst_req  (burst_req),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: queues of stored wide words and pending narrow words.
  logic [OUT_W-1:0] m_store [$];
  logic [IN_W-1:0]  m_lanes [$];
  int               m_mode;       // 0 idle, 1 pad, 2 drain
  logic [OUT_W-1:0] m_out_data;
  bit               m_out_valid, m_burst, m_fd, m_ovf, m_unf;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_word();
    logic [OUT_W-1:0] w;
    w = '0;
    foreach (m_lanes[i]) w[i*IN_W +: IN_W] = m_lanes[i];
    return w;
  endfunction

  task automatic model_clear();
    m_store.delete();
    m_lanes.delete();
    m_mode      = 0;
    m_out_data  = '0;
    m_out_valid = 0;
    m_burst     = 0;
    m_fd        = 0;
    m_ovf       = 0;
    m_unf       = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".level"},      OUT_W'(level),      OUT_W'(m_store.size()));
    chk({tag, ".out_valid"},  OUT_W'(out_valid),  OUT_W'(m_out_valid));
    chk({tag, ".out_data"},   out_data,           m_out_data);
    chk({tag, ".burst_req"},  OUT_W'(burst_req),  OUT_W'(m_burst));
    chk({tag, ".flush_done"}, OUT_W'(flush_done), OUT_W'(m_fd));
    chk({tag, ".overflow"},   OUT_W'(overflow),   OUT_W'(m_ovf));
    chk({tag, ".underflow"},  OUT_W'(underflow),  OUT_W'(m_unf));
  endtask

  // One clock cycle: drive inputs, predict, clock, then compare.
  task automatic step(input bit v, input logic [IN_W-1:0] d, input bit f, input bit p);
    int               old_size, old_mode;
    bit               exp_ready, have_wr, ov_next, fd_next;
    logic [OUT_W-1:0] wr_word;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_rd_en = p;
    old_size  = m_store.size();
    old_mode  = m_mode;
    exp_ready = (m_mode == 0) && (old_size != DEPTH);
    chk("in_ready", OUT_W'(in_ready), OUT_W'(exp_ready));

    have_wr = 0;
    wr_word = '0;
    fd_next = 0;
    if (m_mode == 0 && v && !exp_ready) m_ovf = 1;
    if (v && exp_ready) begin
      m_lanes.push_back(d);
      if (m_lanes.size() == RATIO) begin
        wr_word = model_word();
        have_wr = 1;
        m_lanes.delete();
      end
    end
    case (old_mode)
      0: if (f) m_mode = (m_lanes.size() != 0) ? 1 : 2;
      1: if (old_size != DEPTH) begin
           wr_word = model_word();
           have_wr = 1;
           m_lanes.delete();
           m_mode  = 2;
         end
      default: if (old_size == 0) begin
           fd_next = 1;
           m_mode  = 0;
         end
    endcase

    ov_next = 0;
    if (p) begin
      if (old_size > 0) begin
        m_out_data = m_store.pop_front();
        ov_next    = 1;
      end else begin
        m_unf   = 1;
        have_wr = 0;
      end
    end
    if (have_wr) m_store.push_back(wr_word);
    m_burst     = (old_size >= BURST_LEN) || (old_mode != 0 && old_size > 0);
    m_out_valid = ov_next;
    m_fd        = fd_next;

    @(posedge ddr_clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_rd_en = 1'b0;
    model_clear();
    repeat (2) @(posedge ddr_clk);
    #1;
    rst = 1'b0;
    compare_all("reset");
    chk("reset.in_ready", OUT_W'(in_ready), OUT_W'(1));
  endtask

  task automatic wait_flush_done(input string name);
    int n;
    n = 0;
    while (flush_done !== 1'b1 && n < 8) begin
      step(0, '0, 0, 0);
      n++;
    end
    chk(name, OUT_W'(n), OUT_W'(1));
  endtask

  initial begin
    logic [OUT_W-1:0] lit;
    int               guard;

    do_reset();
    chk("rst.level_lit", OUT_W'(level), '0);
    chk("rst.out_data_lit", out_data, '0);

    // Eight words 1..8 pack into one wide word.
    for (int i = 1; i <= 8; i++) step(1, IN_W'(i), 0, 0);
    step(0, '0, 0, 0);
    lit = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    chk("pack8.level_lit", OUT_W'(level), OUT_W'(1));
    chk("pack8.burst_lit", OUT_W'(burst_req), '0);
    chk("pack8.model_word", m_store[0], lit);
    step(0, '0, 0, 1);
    chk("pack8.pop_lit", out_data, lit);

    // Sixteen wide words build a burst, then drain back to back.
    for (int i = 0; i < 128; i++) step(1, IN_W'(32'h100 + i), 0, 0);
    step(0, '0, 0, 0);
    chk("burst.level_lit", OUT_W'(level), OUT_W'(16));
    chk("burst.req_lit", OUT_W'(burst_req), OUT_W'(1));
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 0, 1);
      chk("burst.beat_valid", OUT_W'(out_valid), OUT_W'(1));
      chk("burst.beat_lane0", OUT_W'(out_data[IN_W-1:0]), OUT_W'(32'h100 + 8 * i));
    end
    step(0, '0, 0, 0);
    chk("burst.empty_lit", OUT_W'(level), '0);
    chk("burst.req_low_lit", OUT_W'(burst_req), '0);

    // Partial group padded by flush.
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    step(1, 32'hC, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("pad.level_lit", OUT_W'(level), OUT_W'(1));
    chk("pad.burst_lit", OUT_W'(burst_req), OUT_W'(1));
    step(0, '0, 0, 1);
    lit = {160'h0, 32'hC, 32'hB, 32'hA};
    chk("pad.word_lit", out_data, lit);
    wait_flush_done("pad.done_latency");

    // Flush with nothing stored and no partial word.
    step(0, '0, 1, 0);
    wait_flush_done("empty.done_latency");

    // Fill to full, then offer one more word.
    for (int i = 0; i < DEPTH * RATIO; i++) step(1, IN_W'($urandom), 0, 0);
    chk("full.level_lit", OUT_W'(level), OUT_W'(DEPTH));
    chk("full.ready_lit", OUT_W'(in_ready), '0);
    step(1, IN_W'($urandom), 0, 0);
    chk("full.ovf_lit", OUT_W'(overflow), OUT_W'(1));
    chk("full.level_hold_lit", OUT_W'(level), OUT_W'(DEPTH));
    step(1, IN_W'($urandom), 0, 1);
    guard = 0;
    while (level != '0 && guard < DEPTH + 8) begin
      step(0, '0, 0, 1);
      guard++;
    end
    chk("full.drain_done", OUT_W'(level), '0);

    // Underflow, then reset in the middle of a group.
    do_reset();
    step(0, '0, 0, 1);
    chk("unf.flag_lit", OUT_W'(underflow), OUT_W'(1));
    chk("unf.valid_lit", OUT_W'(out_valid), '0);
    for (int i = 0; i < 5; i++) step(1, IN_W'(32'hDEAD0000 + i), 0, 0);
    do_reset();
    chk("rstmid.level_lit", OUT_W'(level), '0);
    chk("rstmid.unf_lit", OUT_W'(underflow), '0);
    for (int i = 0; i < 8; i++) step(1, IN_W'(32'h11 + i), 0, 0);
    step(0, '0, 0, 1);
    lit = 256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011;
    chk("rstmid.repack_lit", out_data, lit);

    // Randomized soak: a filling phase then a draining phase.
    for (int i = 0; i < 6000; i++) begin
      bit v, f, p;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 79) == 0);
      p = (i < 3000) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      step(v, IN_W'($urandom), f, p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
